// File: rtl/arbitro_escritura_if.sv
// Bundle of the write-back arbiter's handshake and register-file signals.
// The slave modport is the arbiter side; the master modport is the pipeline/testbench side.
interface arbitro_escritura_if;
    logic        WbValid;
    logic [4:0]  WbReg;
    logic [31:0] WbData;
    logic        LlValid;
    logic        LlReady;
    logic [4:0]  LlReg;
    logic [31:0] LlData;
    logic        IssueValid;
    logic [4:0]  IssueReg;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] Pending;
    logic [4:0]  Count;
    logic        StallReq;

    modport slave (
        input  WbValid, WbReg, WbData,
        input  LlValid, LlReg, LlData,
        input  IssueValid, IssueReg,
        output LlReady,
        output RegWrite, WriteReg, WriteData,
        output Pending, Count, StallReq
    );

    modport master (
        output WbValid, WbReg, WbData,
        output LlValid, LlReg, LlData,
        output IssueValid, IssueReg,
        input  LlReady,
        input  RegWrite, WriteReg, WriteData,
        input  Pending, Count, StallReq
    );
endinterface

// File: rtl/arbitro_escritura.sv
// Single register-file write port shared by the WB stage (always wins) and a FIFO of
// long-latency results, with a pending-register scoreboard and a starvation stall request.
module arbitro_escritura #(
    parameter int DEPTH  = 4,
    parameter int STARVE = 3
) (
    input  logic                clk,
    input  logic                reset,
    arbitro_escritura_if.slave  bus
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int STARVE_W = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [4:0]          DEPTH_C  = 5'(DEPTH);
    localparam logic [STARVE_W-1:0] STARVE_C = STARVE_W'(STARVE);

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_WB,
        SRC_FIFO
    } src_t;

    logic [36:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [4:0]          countQ;
    logic [4:0]          countNext;
    logic [STARVE_W-1:0] starveQ;
    logic [STARVE_W-1:0] starveNext;
    logic [31:0]         pendingQ;
    logic [31:0]         pendingNext;
    logic                regWriteQ;
    logic [4:0]          writeRegQ;
    logic [31:0]         writeDataQ;
    logic                stallQ;
    logic                stallNext;

    logic                llReady;
    logic                push;
    logic                pop;
    logic                fifoEmpty;
    src_t                src;
    logic [36:0]         head;
    logic [4:0]          headReg;
    logic [4:0]          selReg;
    logic [31:0]         selData;
    logic [31:0]         setMask;
    logic [31:0]         clrMask;

    assign fifoEmpty = (countQ == 5'd0);
    assign llReady   = !reset && (countQ < DEPTH_C);
    assign push      = bus.LlValid && llReady;
    assign head      = mem[rdPtr];
    assign headReg   = head[36:32];
    assign pop       = (src == SRC_FIFO);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src     = SRC_IDLE;
        selReg  = 5'd0;
        selData = 32'd0;
        if (bus.WbValid) begin
            src     = SRC_WB;
            selReg  = bus.WbReg;
            selData = bus.WbData;
        end else if (!fifoEmpty) begin
            src     = SRC_FIFO;
            selReg  = headReg;
            selData = head[31:0];
        end
    end

    always_comb begin
        countNext = countQ;
        case ({push, pop})
            2'b10:   countNext = countQ + 5'd1;
            2'b01:   countNext = countQ - 5'd1;
            default: countNext = countQ;
        endcase
    end

    // A head entry only counts as pre-empted while it sits behind a WB write.
    always_comb begin
        starveNext = starveQ;
        if (pop || fifoEmpty) begin
            starveNext = '0;
        end else if (bus.WbValid && (starveQ != STARVE_C)) begin
            starveNext = starveQ + STARVE_W'(1);
        end
    end

    // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
    always_comb begin
        setMask = 32'd0;
        clrMask = 32'd0;
        if (bus.IssueValid && (bus.IssueReg != 5'd0)) begin
            setMask = 32'd1 << bus.IssueReg;
        end
        if (pop && (headReg != 5'd0)) begin
            clrMask = 32'd1 << headReg;
        end
        pendingNext    = (pendingQ & ~clrMask) | setMask;
        pendingNext[0] = 1'b0;
    end

    assign stallNext = (countNext == DEPTH_C) || (starveNext == STARVE_C);

    // NOTE: the entry storage has no reset; emptiness is tracked by countQ alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= {bus.LlReg, bus.LlData};
        end
    end

    // NOTE: all sequential state is updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            countQ     <= 5'd0;
            starveQ    <= '0;
            pendingQ   <= 32'd0;
            regWriteQ  <= 1'b0;
            writeRegQ  <= 5'd0;
            writeDataQ <= 32'd0;
            stallQ     <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            countQ   <= countNext;
            starveQ  <= starveNext;
            pendingQ <= pendingNext;
            stallQ   <= stallNext;
            // Writes to register 0 are suppressed entirely, address and data included.
            if ((src != SRC_IDLE) && (selReg != 5'd0)) begin
                regWriteQ  <= 1'b1;
                writeRegQ  <= selReg;
                writeDataQ <= selData;
            end else begin
                regWriteQ  <= 1'b0;
                writeRegQ  <= 5'd0;
                writeDataQ <= 32'd0;
            end
        end
    end

    assign bus.LlReady   = llReady;
    assign bus.RegWrite  = regWriteQ;
    assign bus.WriteReg  = writeRegQ;
    assign bus.WriteData = writeDataQ;
    assign bus.Pending   = pendingQ;
    assign bus.Count     = countQ;
    assign bus.StallReq  = stallQ;
endmodule

// File: tb/tb_arbitro_escritura.sv
// Directed bench for arbitro_escritura: expected register-file writes are queued as
// stimulus is issued and a negedge monitor compares each write the DUT performs.
module tb_arbitro_escritura;
    logic clk;
    logic reset;

    arbitro_escritura_if bus();

    arbitro_escritura #(.DEPTH(4), .STARVE(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t expq[$];
    int  vectors     = 0;
    int  miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        expq.push_back(e);
    endtask

    task automatic clearInputs();
        bus.WbValid    = 1'b0;
        bus.WbReg      = 5'd0;
        bus.WbData     = 32'd0;
        bus.LlValid    = 1'b0;
        bus.LlReg      = 5'd0;
        bus.LlData     = 32'd0;
        bus.IssueValid = 1'b0;
        bus.IssueReg   = 5'd0;
    endtask

    // Monitor: every write the DUT performs must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.RegWrite) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", 32'(bus.RegWrite), 32'd0);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    check("wr_reg", 32'(bus.WriteReg), 32'(e.r));
                    check("wr_data", bus.WriteData, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] stallExp;

        reset = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(bus.Count), 32'd0);
        check("rst_pending", bus.Pending, 32'd0);
        check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("rst_llready", 32'(bus.LlReady), 32'd0);
        check("rst_stall", 32'(bus.StallReq), 32'd0);
        reset = 1'b0;
        #1;
        check("llready_after_rst", 32'(bus.LlReady), 32'd1);

        // Basic push/pop latency and pending clear
        bus.IssueValid = 1'b1;
        bus.IssueReg   = 5'd5;
        tick();
        bus.IssueValid = 1'b0;
        check("pending_set5", bus.Pending, 32'h20);
        bus.LlValid = 1'b1;
        bus.LlReg   = 5'd5;
        bus.LlData  = 32'hCAFE;
        expectWr(5'd5, 32'hCAFE);
        tick();
        bus.LlValid = 1'b0;
        check("count_push", 32'(bus.Count), 32'd1);
        check("no_bypass", 32'(bus.RegWrite), 32'd0);
        tick();
        check("pop_regwrite", 32'(bus.RegWrite), 32'd1);
        check("pending_clr5", bus.Pending, 32'h0);
        check("count_pop", 32'(bus.Count), 32'd0);
        tick();
        check("idle_regwrite", 32'(bus.RegWrite), 32'd0);

        // WB to register 0 and issue to register 0 are no-ops
        bus.WbValid    = 1'b1;
        bus.WbReg      = 5'd0;
        bus.WbData     = 32'hFFFF;
        bus.IssueValid = 1'b1;
        bus.IssueReg   = 5'd0;
        tick();
        bus.IssueValid = 1'b0;
        check("wb_r0_regwrite", 32'(bus.RegWrite), 32'd0);
        check("wb_r0_data", bus.WriteData, 32'd0);
        check("issue_r0_pending", bus.Pending, 32'd0);
        bus.WbReg  = 5'd3;
        bus.WbData = 32'h1234;
        expectWr(5'd3, 32'h1234);
        tick();
        bus.WbValid = 1'b0;
        check("wb_writereg", 32'(bus.WriteReg), 32'd3);
        tick();

        // WB held busy while five long-latency offers arrive: only four fit
        for (int i = 0; i < 5; i++) begin
            bus.WbValid = 1'b1;
            bus.WbReg   = 5'(i + 1);
            bus.WbData  = 32'hB000 + 32'(i);
            expectWr(5'(i + 1), 32'hB000 + 32'(i));
            bus.LlValid = 1'b1;
            bus.LlReg   = 5'(10 + i);
            bus.LlData  = 32'h1000 + 32'(i);
            check("llready_offer", 32'(bus.LlReady), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        bus.LlValid = 1'b0;
        check("count_full", 32'(bus.Count), 32'd4);
        check("stall_full", 32'(bus.StallReq), 32'd1);
        check("llready_full", 32'(bus.LlReady), 32'd0);
        bus.WbValid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            expectWr(5'(10 + j), 32'h1000 + 32'(j));
        end
        tick();
        check("count_drain1", 32'(bus.Count), 32'd3);
        check("stall_drain1", 32'(bus.StallReq), 32'd0);
        repeat (3) tick();
        check("count_drained", 32'(bus.Count), 32'd0);

        // Starvation: one queued entry pre-empted by WB, saturating at three
        bus.LlValid = 1'b1;
        bus.LlReg   = 5'd9;
        bus.LlData  = 32'h99;
        tick();
        bus.LlValid = 1'b0;
        stallExp = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            bus.WbValid = 1'b1;
            bus.WbReg   = 5'(16 + i);
            bus.WbData  = 32'hD00 + 32'(i);
            expectWr(5'(16 + i), 32'hD00 + 32'(i));
            tick();
            check("starve_stall", 32'(bus.StallReq), 32'(stallExp[i]));
        end
        check("starve_count", 32'(bus.Count), 32'd1);
        bus.WbValid = 1'b0;
        expectWr(5'd9, 32'h99);
        tick();
        check("stall_after_pop", 32'(bus.StallReq), 32'd0);
        check("count_after_starve", 32'(bus.Count), 32'd0);

        // Re-issue on the retiring edge keeps the pending bit set
        bus.IssueValid = 1'b1;
        bus.IssueReg   = 5'd7;
        tick();
        bus.IssueValid = 1'b0;
        bus.LlValid    = 1'b1;
        bus.LlReg      = 5'd7;
        bus.LlData     = 32'h77;
        tick();
        bus.LlValid = 1'b0;
        check("pending7_before", bus.Pending, 32'h80);
        bus.IssueValid = 1'b1;
        bus.IssueReg   = 5'd7;
        expectWr(5'd7, 32'h77);
        tick();
        bus.IssueValid = 1'b0;
        check("pending7_setwins", bus.Pending, 32'h80);

        // Popped entry for register 0 is consumed without a write
        bus.LlValid = 1'b1;
        bus.LlReg   = 5'd0;
        bus.LlData  = 32'h55;
        tick();
        bus.LlValid = 1'b0;
        tick();
        check("pop_r0_regwrite", 32'(bus.RegWrite), 32'd0);
        check("pop_r0_writereg", 32'(bus.WriteReg), 32'd0);
        check("pop_r0_count", 32'(bus.Count), 32'd0);

        // Reset mid-operation with three queued entries and Pending = 0x84
        bus.IssueValid = 1'b1;
        bus.IssueReg   = 5'd2;
        bus.LlValid    = 1'b1;
        bus.WbValid    = 1'b1;
        bus.LlReg      = 5'd20;
        bus.LlData     = 32'h2000;
        bus.WbReg      = 5'd21;
        bus.WbData     = 32'hE0;
        expectWr(5'd21, 32'hE0);
        tick();
        bus.IssueValid = 1'b0;
        bus.LlReg      = 5'd22;
        bus.LlData     = 32'h2001;
        bus.WbReg      = 5'd23;
        bus.WbData     = 32'hE1;
        expectWr(5'd23, 32'hE1);
        tick();
        bus.LlReg  = 5'd24;
        bus.LlData = 32'h2002;
        bus.WbReg  = 5'd25;
        bus.WbData = 32'hE2;
        expectWr(5'd25, 32'hE2);
        tick();
        clearInputs();
        check("pre_rst_count", 32'(bus.Count), 32'd3);
        check("pre_rst_pending", bus.Pending, 32'h84);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.Count), 32'd0);
        check("async_rst_pending", bus.Pending, 32'd0);
        check("async_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("async_rst_llready", 32'(bus.LlReady), 32'd0);
        check("async_rst_stall", 32'(bus.StallReq), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("post_rst_count", 32'(bus.Count), 32'd0);
        bus.LlValid = 1'b1;
        bus.LlReg   = 5'd6;
        bus.LlData  = 32'h66;
        expectWr(5'd6, 32'h66);
        tick();
        bus.LlValid = 1'b0;
        check("first_push_count", 32'(bus.Count), 32'd1);
        tick();
        check("first_push_write", 32'(bus.RegWrite), 32'd1);
        tick();

        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/arbitro_escritura.md
ARBITRO_ESCRITURA -- requirements
Module: arbitro_escritura

Interface
REQ-001 SHALL have parameter DEPTH, default 4: long-latency result FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter STARVE, default 3: consecutive cycles a non-empty FIFO head may be pre-empted before StallReq.
REQ-003 SHALL have port clk  in  1  single system clock; all state on posedge clk.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port WbValid  in  1  pipeline WB stage has a result this cycle; no backpressure.
REQ-006 SHALL have port WbReg  in  5  WB destination register.
REQ-007 SHALL have port WbData  in  32  WB result.
REQ-008 SHALL have port LlValid  in  1  long-latency unit offers a result.
REQ-009 SHALL have port LlReady  out  1  FIFO accepts the offered result.
REQ-010 SHALL have port LlReg  in  5  long-latency destination register.
REQ-011 SHALL have port LlData  in  32  long-latency result.
REQ-012 SHALL have port IssueValid  in  1  long-latency op issued this cycle.
REQ-013 SHALL have port IssueReg  in  5  destination of the issued op.
REQ-014 SHALL have port RegWrite  out  1  register-file write enable, registered.
REQ-015 SHALL have port WriteReg  out  5  register-file write address, registered.
REQ-016 SHALL have port WriteData  out  32  register-file write data, registered.
REQ-017 SHALL have port Pending  out  32  scoreboard: bit n = register n awaits a long-latency result.
REQ-018 SHALL have port Count  out  5  FIFO occupancy, 0..DEPTH.
REQ-019 SHALL have port StallReq  out  1  request to hazard unit to bubble WB next cycle.

Function
REQ-020 LlReady SHALL equal (Count < DEPTH) and not reset; no pass-through when full.
REQ-021 Push SHALL occur on posedge when LlValid && LlReady; entry = {LlReg, LlData}, FIFO order.
REQ-022 Each posedge SHALL select write source: WbValid -> WB input; else FIFO non-empty -> pop head; else idle (RegWrite=0).
REQ-023 Selected source SHALL drive RegWrite/WriteReg/WriteData for the whole following cycle (1-cycle latency), stable across the register file's negedge write.
REQ-024 Selected destination 0 SHALL produce RegWrite=0, WriteReg=0, WriteData=0; a popped entry with register 0 is consumed normally.
REQ-025 Long-latency result SHALL never bypass the FIFO: minimum push-to-RegWrite latency 2 cycles.
REQ-026 Simultaneous push and pop SHALL leave Count unchanged; Count SHALL never exceed DEPTH or underflow.
REQ-027 IssueValid with IssueReg != 0 SHALL set Pending[IssueReg] at posedge; Pending[0] SHALL be constant 0.
REQ-028 Popping an entry with register r != 0 SHALL clear Pending[r] at the same posedge.
REQ-029 Same-cycle set and clear of the same bit SHALL resolve to set.
REQ-030 WB writes SHALL NOT modify Pending.
REQ-031 Starvation counter SHALL increment when FIFO non-empty and WbValid, reset to 0 on any pop or when FIFO empty, saturate at STARVE.
REQ-032 StallReq SHALL be registered, =1 when Count == DEPTH or starvation counter == STARVE, else 0.
REQ-033 Hazard unit honoring StallReq guarantees WbValid=0 next cycle; arbiter SHALL remain correct if it does not (WB still wins).

Reset
REQ-034 reset SHALL asynchronously clear FIFO pointers, Count=0, Pending=0, RegWrite=0, WriteReg=0, WriteData=0, StallReq=0, starvation counter=0, LlReady=0.
REQ-035 Reset mid-operation SHALL discard queued entries and pending bits; first push possible on first posedge after deassertion.

Verification
REQ-036 LlValid, LlReg=5, LlData=0xCAFE, WbValid=0, FIFO empty -> push edge k, RegWrite=1 WriteReg=5 WriteData=0xCAFE during cycle k+2, Pending[5] cleared same edge.
REQ-037 DEPTH=4, WbValid held 1, 5 Ll offers -> 4 accepted, LlReady=0 at Count=4, StallReq=1, all WB writes in order.
REQ-038 FIFO holds 1 entry, WbValid=1 for 3 cycles -> StallReq=1 after third pre-emption; WbValid=0 -> pop, StallReq=0 next edge.
REQ-039 IssueValid IssueReg=7 same edge as pop of register 7 -> Pending[7]=1 afterward.
REQ-040 WbValid WbReg=0 WbData=0xFFFF -> RegWrite=0 next cycle; IssueReg=0 -> Pending unchanged.
REQ-041 Reset asserted with Count=3, Pending=0x84 -> immediate Count=0, Pending=0, RegWrite=0, LlReady=0, no queued write after release.
